// File: rtl/sdram_pkg.sv
// Shared defaults and request record for the SDRAM request queue.
package sdram_pkg;

   localparam int SDRAM_ADDR_W        = 25;
   localparam int SDRAM_DATA_W        = 8;
   localparam int SDRAM_REQ_DEPTH     = 4;
   localparam int SDRAM_RD_PEND_DEPTH = 4;

   typedef struct packed {
      logic                    we;
      logic [SDRAM_ADDR_W-1:0] addr;
      logic [SDRAM_DATA_W-1:0] wdata;
   } sdram_req_t;

   // Flat width of a request record for non-default address/data widths.
   function automatic int req_width(input int aw, input int dw);
      return 1 + aw + dw;
   endfunction

endpackage

// File: rtl/sdram_sync_fifo.sv
// Synchronous FIFO with show-ahead head; push+pop at full is accepted and keeps occupancy.
// Zero-latency read of the head entry; a push while full without a pop is dropped.
module sdram_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_dat,
   output logic [WIDTH-1:0]       o_dat,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dat     = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_dat;
   end

endmodule

// File: rtl/sdram_req_queue.sv
// In-order SDRAM request queue with read-pending tracker; responses 1 cycle after ctl_val, no rsp backpressure.
// SDRAM_REQ_ADDR_ECHO_EN: tracker stores addresses and rsp_addr echoes them; otherwise rsp_addr is 0.
module sdram_req_queue
   import sdram_pkg::*;
#(
   parameter int ADDR_DEPTH    = SDRAM_ADDR_W,
   parameter int DATA_WIDTH    = SDRAM_DATA_W,
   parameter int REQ_DEPTH     = SDRAM_REQ_DEPTH,
   parameter int RD_PEND_DEPTH = SDRAM_RD_PEND_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_we,
   input  logic [ADDR_DEPTH-1:0]      req_addr,
   input  logic [DATA_WIDTH-1:0]      req_wdata,
   output logic                       ctl_wr,
   output logic                       ctl_rd,
   output logic [ADDR_DEPTH-1:0]      ctl_addr,
   output logic [DATA_WIDTH-1:0]      ctl_data_wr,
   input  logic                       ctl_rdy,
   input  logic                       ctl_val,
   input  logic [DATA_WIDTH-1:0]      ctl_data_rd,
   output logic                       rsp_valid,
   output logic [DATA_WIDTH-1:0]      rsp_data,
   output logic [ADDR_DEPTH-1:0]      rsp_addr,
   output logic [$clog2(REQ_DEPTH):0] req_level,
   output logic                       err_unexp_val
);

   localparam int REQ_W  = req_width(ADDR_DEPTH, DATA_WIDTH);
   localparam int PEND_W = $clog2(RD_PEND_DEPTH) + 1;

   // Flat record layout matches sdram_req_t: {we, addr, wdata}.
   logic [REQ_W-1:0]      w_push_dat;
   logic [REQ_W-1:0]      w_head;
   logic                  w_req_full;
   logic                  w_req_empty;
   logic                  w_req_push;
   logic                  w_req_pop;
   logic                  w_rd_issue;
   logic                  w_trk_pop;
   logic                  w_trk_full;
   logic                  w_trk_empty;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                  r_err;

   assign w_push_dat = {req_we, req_addr, req_wdata};
   assign req_ready  = !w_req_full;
   assign w_req_push = req_valid && !w_req_full;

   sdram_sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_req_push),
      .i_pop   (w_req_pop),
      .i_dat   (w_push_dat),
      .o_dat   (w_head),
      .o_full  (w_req_full),
      .o_empty (w_req_empty),
      .o_count (req_level)
   );

   assign ctl_addr    = w_head[DATA_WIDTH +: ADDR_DEPTH];
   assign ctl_data_wr = w_head[DATA_WIDTH-1:0];
   assign ctl_wr      = !w_req_empty && w_head[REQ_W-1];
   assign ctl_rd      = !w_req_empty && !w_head[REQ_W-1] && !w_trk_full;
   assign w_req_pop   = ctl_rdy && (ctl_wr || ctl_rd);
   assign w_rd_issue  = ctl_rdy && ctl_rd;
   assign w_trk_pop   = ctl_val && !w_trk_empty;

`ifdef SDRAM_REQ_ADDR_ECHO_EN
   logic [ADDR_DEPTH-1:0] w_trk_addr;
   logic [ADDR_DEPTH-1:0] r_rsp_addr;
   logic [PEND_W-1:0]     w_trk_level_unused;

   sdram_sync_fifo #(.WIDTH(ADDR_DEPTH), .DEPTH(RD_PEND_DEPTH)) u_trk_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_rd_issue),
      .i_pop   (w_trk_pop),
      .i_dat   (ctl_addr),
      .o_dat   (w_trk_addr),
      .o_full  (w_trk_full),
      .o_empty (w_trk_empty),
      .o_count (w_trk_level_unused)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_rsp_addr <= '0;
      else if (w_trk_pop) r_rsp_addr <= w_trk_addr;
   end

   assign rsp_addr = r_rsp_addr;
`else
   logic [PEND_W-1:0] r_pend_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_cnt <= '0;
      end else begin
         case ({w_rd_issue, w_trk_pop})
            2'b10:   r_pend_cnt <= r_pend_cnt + PEND_W'(1);
            2'b01:   r_pend_cnt <= r_pend_cnt - PEND_W'(1);
            default: r_pend_cnt <= r_pend_cnt;
         endcase
      end
   end

   assign w_trk_full  = (r_pend_cnt == PEND_W'(RD_PEND_DEPTH));
   assign w_trk_empty = (r_pend_cnt == '0);
   assign rsp_addr    = '0;
`endif

   // A stray ctl_val only raises the sticky error; it never reaches the response port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_rsp_valid <= w_trk_pop;
         if (w_trk_pop)              r_rsp_data <= ctl_data_rd;
         if (ctl_val && w_trk_empty) r_err      <= 1'b1;
      end
   end

   assign rsp_valid     = r_rsp_valid;
   assign rsp_data      = r_rsp_data;
   assign err_unexp_val = r_err;

endmodule

// File: doc/sdram_req_queue.md
SDRAM_REQ_QUEUE -- requirements
Module: sdram_req_queue

Interface
REQ-001 Parameter ADDR_DEPTH, default 25, SDRAM word address width.
REQ-002 Parameter DATA_WIDTH, default 8, client data width.
REQ-003 Parameter REQ_DEPTH, default 4, request FIFO entries; power of two, >=2.
REQ-004 Parameter RD_PEND_DEPTH, default 4, max outstanding reads; power of two, >=2.
REQ-005 clk  input  1  single clock; all logic on posedge clk.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  client request present.
REQ-008 req_ready  output  1  queue can accept a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_DEPTH  request address.
REQ-011 req_wdata  input  DATA_WIDTH  write data, ignored for reads.
REQ-012 ctl_wr / ctl_rd  output  1 each  controller write/read strobes, never both high.
REQ-013 ctl_addr / ctl_data_wr  output  ADDR_DEPTH / DATA_WIDTH  head-of-queue address and data to controller.
REQ-014 ctl_rdy  input  1  controller accepted the presented command (one-cycle pulse).
REQ-015 ctl_val  input  1  controller read data valid (one-cycle pulse, in read-issue order).
REQ-016 ctl_data_rd  input  DATA_WIDTH  controller read data.
REQ-017 rsp_valid  output  1  read response pulse; no backpressure.
REQ-018 rsp_data  output  DATA_WIDTH  read data.
REQ-019 rsp_addr  output  ADDR_DEPTH  address of the returned read (see Configuration).
REQ-020 req_level  output  $clog2(REQ_DEPTH)+1  current request FIFO occupancy.
REQ-021 err_unexp_val  output  1  sticky: ctl_val seen with no read pending.

Function
REQ-022 Request accepted on req_valid && req_ready; req_ready = request FIFO not full (registered count, no same-cycle pop credit).
REQ-023 Head entry drives ctl_addr/ctl_data_wr combinationally; ctl_wr = nonempty && head.we; ctl_rd = nonempty && !head.we && pending tracker not full.
REQ-024 Head pops on ctl_rdy while ctl_wr or ctl_rd is high; ctl_rdy with both low is ignored.
REQ-025 When a read head pops, its address is pushed into the pending-read tracker in the same cycle.
REQ-026 On ctl_val, tracker pops; rsp_valid, rsp_data, rsp_addr registered, appear exactly 1 cycle after ctl_val.
REQ-027 Simultaneous tracker push (read pop) and pop (ctl_val) in one cycle: both occur, occupancy unchanged; legal at full.
REQ-028 Simultaneous request push and head pop: both occur, req_level unchanged.
REQ-029 Tracker full with read at head: ctl_rd held low, head stalls; writes behind it never bypass (strict order).
REQ-030 ctl_val with tracker empty: err_unexp_val set, rsp_valid stays low, tracker pointers unchanged.
REQ-031 FIFO pointers wrap modulo depth; occupancy never exceeds depth.

Reset
REQ-032 On rst: both FIFOs empty, req_ready=1 after release, ctl_wr=ctl_rd=0, rsp_valid=0, rsp_data=0, rsp_addr=0, req_level=0, err_unexp_val=0.
REQ-033 Reset mid-operation discards queued and pending entries; ctl_val arriving after reset without a post-reset read sets err_unexp_val.

Configuration
REQ-034 Macro SDRAM_REQ_ADDR_ECHO_EN defined: tracker stores addresses, rsp_addr carries the returned read's address.
REQ-035 Macro undefined: tracker holds only occupancy (counter, no address storage), rsp_addr tied to 0; all other behaviour identical.

Structure
REQ-036 Package sdram_pkg holds typedef sdram_req_t {we, addr, wdata} and default-width localparams.
REQ-037 One sub-module sdram_sync_fifo (parameterised width/depth, push/pop/full/empty/count) instantiated for the request queue and, with echo enabled, the tracker.

Verification
REQ-038 Reset, then 4 writes addr 0..3 data 0xA0..0xA3 with ctl_rdy every other cycle -> ctl_wr sequence addr 0,1,2,3, req_level 4->0, ctl_rd never high.
REQ-039 5 back-to-back requests, no ctl_rdy -> req_ready low after 4th, 5th held, req_level=4.
REQ-040 Reads addr 0x10..0x13, ctl_val 3 cycles after each ctl_rdy with data 0x55..0x58 -> rsp_valid pulses 1 cycle after each ctl_val, rsp_data 0x55..0x58, rsp_addr 0x10..0x13 (echo on) or 0 (echo off).
REQ-041 6 reads, ctl_val withheld -> exactly 4 ctl_rdy-accepted, ctl_rd low with reads 5-6 queued; one ctl_val -> ctl_rd reasserts same cycle tracker drops.
REQ-042 ctl_val with nothing pending -> err_unexp_val=1 and sticky, rsp_valid=0; rst clears it.
REQ-043 rst asserted with 2 queued, 2 pending -> all outputs reset values next edge, req_level=0.
